// File: rtl/threeway_pkg.sv
// Shared 3-Way constants, FSM encoding and word-level helpers.
// Used by both the encrypt and decrypt datapaths.
package threeway_pkg;

  localparam logic [15:0] RC_DEC_START = 16'hB1B1;
  localparam logic [16:0] RC_POLY = 17'h11011;
  localparam int NUM_ROUNDS = 11;
  localparam logic [3:0] CNT_LAST = 4'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_e;

  function automatic logic [95:0] mu(
    input logic [95:0] v
  );
    logic [95:0] r;
    for (int i = 0; i < 96; i++) begin
      r[i] = v[95-i];
    end
    return r;
  endfunction

  function automatic logic [95:0] pi_1(
    input logic [95:0] v
  );
    logic [31:0] a0, a2;
    a0 = {v[9:0], v[31:10]};
    a2 = {v[94:64], v[95]};
    return {a2, v[63:32], a0};
  endfunction

  function automatic logic [95:0] pi_2(
    input logic [95:0] v
  );
    logic [31:0] a0, a2;
    a0 = {v[30:0], v[31]};
    a2 = {v[73:64], v[95:74]};
    return {a2, v[63:32], a0};
  endfunction

  function automatic logic [95:0] gamma(
    input logic [95:0] v
  );
    logic [31:0] a0, a1, a2;
    logic [31:0] b0, b1, b2;
    {a2, a1, a0} = v;
    b0 = a0 ^ (a1 | ~a2);
    b1 = a1 ^ (a2 | ~a0);
    b2 = a2 ^ (a0 | ~a1);
    return {b2, b1, b0};
  endfunction

  function automatic logic [15:0] rc_next(
    input logic [15:0] rc
  );
    logic [16:0] t;
    t = {rc, 1'b0};
    if (t[16]) t = t ^ RC_POLY;
    return t[15:0];
  endfunction

  // rc lands in the top half of a0 and bottom half of a2
  function automatic logic [95:0] rc_mask(
    input logic [15:0] rc
  );
    return {16'h0, rc, 32'h0, rc, 16'h0};
  endfunction

endpackage

// File: rtl/threeway_decrypt_if.sv
// Ciphertext-in / plaintext-out handshake bundle.
// master drives blocks in and drains results; slave is the core.
interface threeway_decrypt_if;

  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic [95:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;

  modport master (
    output in_valid, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/linear.sv
// 3-Way theta: word-mixing linear layer.
// Purely combinational, shared between rounds and key schedule.
module linear (
  input  logic [95:0] a_i,
  output logic [95:0] y_o
);

  logic [31:0] a0, a1, a2;

  assign {a2, a1, a0} = a_i;

  assign y_o[31:0] =
    a0 ^ (a0 >> 16) ^ (a1 << 16) ^ (a1 >> 16) ^
    (a2 << 16) ^ (a1 >> 24) ^ (a2 << 8) ^
    (a2 >> 8) ^ (a0 << 24) ^ (a2 >> 16) ^
    (a0 << 16) ^ (a2 >> 24) ^ (a0 << 8);

  assign y_o[63:32] =
    a1 ^ (a1 >> 16) ^ (a2 << 16) ^ (a2 >> 16) ^
    (a0 << 16) ^ (a2 >> 24) ^ (a0 << 8) ^
    (a0 >> 8) ^ (a1 << 24) ^ (a0 >> 16) ^
    (a1 << 16) ^ (a0 >> 24) ^ (a1 << 8);

  assign y_o[95:64] =
    a2 ^ (a2 >> 16) ^ (a0 << 16) ^ (a0 >> 16) ^
    (a1 << 16) ^ (a0 >> 24) ^ (a1 << 8) ^
    (a1 >> 8) ^ (a2 << 24) ^ (a1 >> 16) ^
    (a2 << 16) ^ (a1 >> 24) ^ (a2 << 8);

endmodule

// File: rtl/threeway_round.sv
// One 3-Way round: key add then rho = pi_2(gamma(pi_1(theta))).
// ka_o is exported so the final transform can reuse it.
module threeway_round
  import threeway_pkg::*;
(
  input  logic [95:0] a_i,
  input  logic [95:0] k_i,
  input  logic [15:0] rc_i,
  output logic [95:0] ka_o,
  output logic [95:0] rho_o
);

  logic [95:0] th;

  assign ka_o = a_i ^ k_i ^ rc_mask(rc_i);

  linear u_theta (
    .a_i (ka_o),
    .y_o (th)
  );

  assign rho_o = pi_2(gamma(pi_1(th)));

endmodule

// File: rtl/threeway_decrypt.sv
// Iterative 3-Way decryptor, one round per clock.
// FSM: IDLE -> ROUND x11 -> FINAL -> DONE -> IDLE.
module threeway_decrypt
  import threeway_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  threeway_decrypt_if.slave    bus
);

  state_e      state_q;
  logic [95:0] a_q;
  logic [95:0] ki_q;
  logic [15:0] rc_q;
  logic [3:0]  cnt_q;

  logic [95:0] ka_d;
  logic [95:0] rho_d;
  logic [95:0] th_in;
  logic [95:0] th_d;

  threeway_round u_round (
    .a_i   (a_q),
    .k_i   (ki_q),
    .rc_i  (rc_q),
    .ka_o  (ka_d),
    .rho_o (rho_d)
  );

  // key theta in IDLE, output theta in FINAL
  assign th_in = (state_q == FINAL) ? ka_d
                                    : bus.in_key;

  linear u_theta (
    .a_i (th_in),
    .y_o (th_d)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = a_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      ki_q    <= '0;
      rc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= mu(bus.in_data);
            ki_q    <= mu(th_d);
            rc_q    <= RC_DEC_START;
            cnt_q   <= '0;
            state_q <= ROUND;
          end
        end
        ROUND: begin
          a_q  <= rho_d;
          rc_q <= rc_next(rc_q);
          if (cnt_q == CNT_LAST) begin
            state_q <= FINAL;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        FINAL: begin
          a_q     <= mu(th_d);
          state_q <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_threeway_decrypt.sv
// Scoreboard bench for threeway_decrypt: ciphertexts come from an
// in-bench 3-Way encryptor, so every output must equal its plaintext.
module tb_threeway_decrypt;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  threeway_decrypt_if bus();

  threeway_decrypt dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int n_exp  = 0;
  int n_out  = 0;
  logic [95:0] exp_q[$];

  bit   rand_rdy = 1'b0;
  logic rdy_r = 1'b0;
  logic rdy_m = 1'b0;
  assign bus.out_ready = rand_rdy ? rdy_r : rdy_m;

  always @(posedge clk) begin
    #1;
    rdy_r = ($urandom_range(0, 3) != 0);
  end

  logic [15:0] rc_tab [12] = '{
    16'hB1B1, 16'h7373, 16'hE6E6, 16'hDDDD,
    16'hABAB, 16'h4747, 16'h8E8E, 16'h0D0D,
    16'h1A1A, 16'h3434, 16'h6868, 16'hD0D0
  };

  // ---------------- reference encryptor ----------------
  function automatic logic [95:0] m_theta(
    input logic [95:0] v
  );
    logic [31:0] a [3];
    logic [31:0] b [3];
    int j, m;
    for (int i = 0; i < 3; i++) a[i] = v[32*i +: 32];
    for (int i = 0; i < 3; i++) begin
      j = (i + 1) % 3;
      m = (i + 2) % 3;
      b[i] = a[i] ^ (a[i] >> 16) ^ (a[j] << 16) ^
             (a[j] >> 16) ^ (a[m] << 16) ^
             (a[j] >> 24) ^ (a[m] << 8) ^
             (a[m] >> 8) ^ (a[i] << 24) ^
             (a[m] >> 16) ^ (a[i] << 16) ^
             (a[m] >> 24) ^ (a[i] << 8);
    end
    return {b[2], b[1], b[0]};
  endfunction

  function automatic logic [95:0] m_rho(
    input logic [95:0] v
  );
    logic [31:0] a0, a1, a2, b0, b1, b2;
    {a2, a1, a0} = m_theta(v);
    a0 = (a0 >> 10) | (a0 << 22);
    a2 = (a2 << 1) | (a2 >> 31);
    b0 = a0 ^ (a1 | ~a2);
    b1 = a1 ^ (a2 | ~a0);
    b2 = a2 ^ (a0 | ~a1);
    b0 = (b0 << 1) | (b0 >> 31);
    b2 = (b2 >> 10) | (b2 << 22);
    return {b2, b1, b0};
  endfunction

  function automatic logic [95:0] m_encrypt(
    input logic [95:0] pt,
    input logic [95:0] k
  );
    logic [95:0] a;
    int unsigned rc;
    a  = pt;
    rc = 32'h0B0B;
    for (int r = 0; r < 12; r++) begin
      a = a ^ k ^ {16'h0, rc[15:0], 32'h0, rc[15:0], 16'h0};
      if (r == 11) a = m_theta(a);
      else a = m_rho(a);
      rc = rc << 1;
      if ((rc & 32'h10000) != 0) rc = rc ^ 32'h11011;
    end
    return a;
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk(
    input string nm,
    input logic [95:0] act,
    input logic [95:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(
    input string nm,
    input logic act,
    input logic exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  // called at posedge+1; returns at posedge+1 after acceptance
  task automatic send(
    input logic [95:0] pt,
    input logic [95:0] k
  );
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = m_encrypt(pt, k);
    bus.in_key   = k;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout in_ready=0 want=1");
    end else begin
      exp_q.push_back(pt);
      n_exp++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom, $urandom};
    bus.in_key   = {$urandom, $urandom, $urandom};
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain_left=%0d want=0", nm, exp_q.size());
    end
  endtask

  // ---------------- monitor ----------------
  bit          hold = 1'b0;
  logic [95:0] hold_d;

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk1("stall_valid", bus.out_valid, 1'b1);
        chk("stall_data", bus.out_data, hold_d);
      end
      if (bus.out_valid) chk1("busy_in_ready", bus.in_ready, 1'b0);
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output got=%h want=none", bus.out_data);
        end else begin
          chk("roundtrip", bus.out_data, exp_q.pop_front());
        end
      end
      hold   = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
    end
  end

  // ---------------- stimulus ----------------
  logic [95:0] kat_pt;
  logic [95:0] pt, key;

  initial begin
    kat_pt       = 96'h00000001_00000001_00000001;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_key   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_data", bus.out_data, 96'h0);
    chk("rst_rc", {80'h0, dut.rc_q}, 96'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk1("idle_in_ready", bus.in_ready, 1'b1);

    // known answer, rc trace, busy in_valid, exact latency
    send(kat_pt, 96'h0);
    chk("rc_trace0", {80'h0, dut.rc_q}, {80'h0, rc_tab[0]});
    for (int j = 1; j < 12; j++) begin
      bus.in_valid = (j % 2) == 1;
      bus.in_data  = {$urandom, $urandom, $urandom};
      bus.in_key   = {$urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      chk($sformatf("rc_trace%0d", j), {80'h0, dut.rc_q},
          {80'h0, rc_tab[j]});
    end
    chk("cnt_end", {92'h0, dut.cnt_q}, 96'd10);
    chk1("lat_early", bus.out_valid, 1'b0);
    @(posedge clk);
    #1;
    chk1("lat_12", bus.out_valid, 1'b1);
    chk("kat", bus.out_data, kat_pt);

    // backpressure with in_valid churn while DONE
    for (int j = 0; j < 20; j++) begin
      bus.in_valid = $urandom_range(0, 1) == 1;
      bus.in_data  = {$urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
      chk1("bp_valid", bus.out_valid, 1'b1);
      chk("bp_data", bus.out_data, kat_pt);
      chk1("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    rdy_m = 1'b1;
    @(posedge clk);
    #1;
    rdy_m = 1'b0;
    chk1("rel_out_valid", bus.out_valid, 1'b0);
    chk1("rel_in_ready", bus.in_ready, 1'b1);

    // reset mid-round, then a fresh block
    pt  = {$urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom};
    send(pt, key);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    n_exp--;
    chk1("mid_rst_in_ready", bus.in_ready, 1'b1);
    chk1("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_out_data", bus.out_data, 96'h0);
    rdy_m = 1'b1;
    pt  = {$urandom, $urandom, $urandom};
    key = {$urandom, $urandom, $urandom};
    send(pt, key);
    drain("after_rst");
    rdy_m = 1'b0;

    // random roundtrip with gaps on both sides
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      pt  = {$urandom, $urandom, $urandom};
      key = {$urandom, $urandom, $urandom};
      if (i == 0) key = '0;
      if (i == 1) pt = '1;
      send(pt, key);
    end
    drain("random");
    rand_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("out_count", 96'(n_out), 96'(n_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/threeway_decrypt.md
# threeway_decrypt

Iterative 3-Way block decryptor. It accepts one 96-bit ciphertext and a 96-bit key over a valid/ready handshake, then runs the 11 inverse rounds plus the final output transform, one round per clock. It returns the 96-bit plaintext over a second valid/ready handshake. It is the receive-side counterpart of the encryptor datapath and reuses the team's `linear` theta layer.

## Interface
- No parameters; round count (11) and start constant fixed in package.
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  ciphertext/key present
- `in_ready`  out  1  block idle, can accept
- `in_data`  in  96  ciphertext; word a0=[31:0], a1=[63:32], a2=[95:64]
- `in_key`  in  96  key, same word mapping; sampled with `in_data`
- `out_valid`  out  1  plaintext present
- `out_ready`  in  1  consumer accepts
- `out_data`  out  96  plaintext, same word mapping

## Operation
- mu(v) is the full 96-bit bit reversal: out[i] = v[95-i]. theta is the `linear` transform.
- pi_1 rotates a0 right by 10 and a2 left by 1.
- pi_2 rotates a0 left by 1 and a2 right by 10.
- gamma, word-wise: b0 = a0 ^ (a1 | ~a2), b1 = a1 ^ (a2 | ~a0), b2 = a2 ^ (a0 | ~a1).
- rho(v) = pi_2(gamma(pi_1(theta(v)))).
- Key add ka(v, k, rc): a0 ^= k0 ^ (rc<<16); a1 ^= k1; a2 ^= k2 ^ rc. rc is 16-bit, zero-extended.
- rc update: rc = rc<<1 over 17 bits; if bit 16 is set, xor 0x11011. Result is 16 bits.
- Decrypt rc sequence: B1B1, 7373, E6E6, DDDD, ABAB, 4747, 8E8E, 0D0D, 1A1A, 3434, 6868, D0D0.
- FSM states:
  - IDLE: `in_ready`=1. On handshake: a←mu(in_data), ki←mu(theta(in_key)), rc←B1B1, cnt←0, go to ROUND.
  - ROUND: a←rho(ka(a,ki,rc)), rc←next, cnt++. When cnt reaches 10 this edge, go to FINAL.
  - FINAL: a←mu(theta(ka(a,ki,rc))), go to DONE. rc used here is D0D0.
  - DONE: `out_valid`=1, `out_data`=a held stable. On `out_ready`, go to IDLE.
- No overlap: a new block is accepted only in IDLE.
- `in_data`/`in_key` are don't-care outside the handshake cycle.
- `out_ready` is ignored outside DONE.
- `rst` mid-operation aborts: the block state is discarded and no output is produced.

## Timing
- Reset values:
  - state=IDLE, `in_ready`=1, `out_valid`=0.
  - `out_data`=0; a, ki, rc, cnt all 0.
- Input handshake at edge E0. Rounds at E1..E11. Final at E12. `out_valid` is high from the cycle after E12, giving a latency of 12 cycles.
- `out_valid` held with stable data until `out_ready`.
- `in_ready` rises the cycle after the output handshake, so the minimum period is 14 cycles per block.
- `in_ready` is a pure state decode, with no combinational path from `in_valid`.
- `out_valid` is a state decode; `out_data` is registered.
- `rst` has priority over all handshakes, including `rst` during the input or output handshake cycle.

## Structure
- Package `threeway_pkg`:
  - RC_DEC_START=16'hB1B1, RC_POLY=17'h11011, NUM_ROUNDS=11.
  - FSM enum {IDLE, ROUND, FINAL, DONE}.
  - Functions mu, pi_1, pi_2, gamma, rc_next. These are shared with the encryptor.
- Sub-module `threeway_round`: combinational ka + theta (`linear` instance) + pi_1 + gamma + pi_2.
  - Second `linear` instance for the key/final theta. The key theta and final theta are used in different states, so one instance is muxed.
- Top holds the FSM, the a/ki/rc/cnt registers and the handshake logic; roughly 150–250 lines.

## Test plan
- Known answer: in_key=0, in_data=encryptor(key=0, pt=96'h00000001_00000001_00000001).
  - Required: `out_data`=96'h00000001_00000001_00000001, `out_valid` rising exactly 12 cycles after acceptance.
- rc trace: probe rc at each ROUND/FINAL edge.
  - Required: the sequence B1B1…D0D0 (12 values), cnt ending at 10.
- Backpressure: hold `out_ready`=0 for 20 cycles.
  - Required: `out_valid` stays 1, `out_data` stable, `in_ready`=0 throughout. Release → one-cycle handshake, then `in_ready`=1 the next cycle.
- Random roundtrip: 1000 random key/pt pairs encrypted by the C golden model, with random `in_valid`/`out_ready` gaps.
  - Required: every plaintext recovered, in order, with no drops or duplicates.
- Reset mid-round: assert `rst` at E6 for one cycle.
  - Required: next cycle `in_ready`=1, `out_valid`=0, `out_data`=0. A fresh block then decrypts correctly.
- `in_valid` while busy: toggle `in_valid` with changing data during ROUND/DONE.
  - Required: no capture, result unaffected.
